dram_wb_bridge: RTL and testbench
=================================

// Module: dram_wb_bridge
// PURPOSE
//  Wishbone classic slave fronting a native DRAM-controller user port. Posts writes into a
//  command FIFO and acks them on push. Reads are queued behind pending writes and acked when
//  read data returns. Sits between a system-bus master and the DRAM controller/PHY.
// PARAMETERS
//  SYS_CLK_FREQ  100_000_000  sys_clk frequency in Hz; informational, no timing derived from it
//  WORD_SIZE     256          data word width in bits (multiple of 8)
//  ADDR_WIDTH    25           DRAM word-address width; mem addr = addr_i[31 -: ADDR_WIDTH]
//  FIFO_DEPTH    8            command FIFO entries (power of 2, >=2)
// PORTS
//  sys_clk          in   1           single clock; all logic on posedge
//  rst              in   1           synchronous, active-high reset
//  initialized      out  1           DRAM ready (registered mem_init_done)
//  cyc_i            in   1           WB cycle
//  stb_i            in   1           WB strobe
//  we_i             in   1           1=write, 0=read
//  addr_i           in   32          WB byte address
//  data_i           in   WORD_SIZE   write data
//  data_o           out  WORD_SIZE   read data, valid with ack_o
//  ack_o            out  1           one-cycle transfer acknowledge
//  mem_init_done    in   1           controller calibration complete
//  mem_cmd_valid    out  1           FIFO head valid (= !empty)
//  mem_cmd_ready    in   1           controller accepts head; pop on valid&ready
//  mem_cmd_we       out  1           head is write
//  mem_cmd_addr     out  ADDR_WIDTH  head word address
//  mem_wdata        out  WORD_SIZE   head write data
//  mem_rdata        in   WORD_SIZE   read return data
//  mem_rdata_valid  in   1           read return strobe
// BEHAVIOUR
//  - Reset: ack_o=0, data_o=0, initialized=0, FIFO empty, read_pending=0, state IDLE.
//  - initialized <= mem_init_done every cycle; can deassert if controller drops it.
//  - FSM IDLE/WAIT_RD/ACK. Sample request only in IDLE: req = cyc_i&stb_i&initialized.
//  - IDLE & req & we_i & !full:
//      push {1,addr,data_i}; ack_o=1 next cycle; go to ACK.
//      Write latency is 1 cycle.
//  - IDLE & req & !we_i & !full:
//      push {0,addr,-}; set read_pending; go to WAIT_RD.
//  - IDLE & req & full: stall; no push, no ack.
//  - WAIT_RD & mem_rdata_valid:
//      data_o<=mem_rdata; ack_o=1 next cycle if cyc_i still high; clear read_pending; go to ACK.
//  - WAIT_RD & cyc_i low (abort): read still completes on the memory side; its return is
//    discarded; no ack; go to IDLE.
//  - ACK lasts exactly one cycle: ack_o deasserts, bus not sampled, then IDLE.
//    This prevents a double accept when the master drops stb the cycle after ack.
//  - mem_rdata_valid with no read pending: ignored.
//  - Simultaneous push and pop: allowed; count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  - Commands leave FIFO in order, so read-after-write to the same address returns new data.
//  - data_o holds last read value until next read return.
//  - Reset mid-operation: FIFO flushed, FSM to IDLE, no ack.
//    Returns arriving after reset are ignored.
// CONFIGURATION
//  WB_ERR_EN defined: adds output err_o (1 bit, reset 0).
//    An IDLE request while initialized=0 gives a one-cycle err_o pulse, then ACK state, no push.
//  Not defined: no err_o port; such requests stall until initialized=1.
// STRUCTURE
//  Package dram_wb_pkg: state enum state_t {IDLE,WAIT_RD,ACK}, cmd struct {we,addr,data}.
//  Sub-module dram_wb_cmd_fifo: sync FIFO, parameters WIDTH/DEPTH.
//    Ports push/pop/full/empty/din/dout; head shown combinationally.
// TESTING
//  1 rst 3 cycles, mem_init_done=1 at cycle 10 -> initialized=1 at cycle 11; earlier stb gets no ack.
//  2 write addr_i=0, data {32{8'hA5}} -> ack next cycle; mem_cmd we=1 addr=0 wdata=A5..; popped.
//  3 read addr_i=0, model returns A5.. after 10 cycles -> data_o={32{8'hA5}} with 1-cycle ack_o.
//  4 mem_cmd_ready=0, 8 writes -> 8 acks; 9th stalls until ready=1, then ack.
//  5 read, then drop cyc_i before return -> no ack, IDLE; later write addr {25'h1,7'h0} acks,
//    mem_cmd_addr=1.
//  6 WB_ERR_EN, mem_init_done=0, stb -> err_o pulse 1 cycle, no FIFO push, ack_o=0.

Source files
------------

// File: rtl/dram_wb_pkg.sv
// Shared types for the Wishbone-to-DRAM bridge: FSM state encoding, default geometry and
// the command record layout at default widths.
package dram_wb_pkg;

   localparam int unsigned DEF_WORD_SIZE  = 256;
   localparam int unsigned DEF_ADDR_WIDTH = 25;
   localparam int unsigned DEF_FIFO_DEPTH = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_RD = 2'd1,
      ACK     = 2'd2
   } state_t;

   typedef struct packed {
      logic                      we;
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_WORD_SIZE-1:0]  data;
   } cmd_t;

endpackage

// File: rtl/dram_wb_bridge_if.sv
// Wishbone classic bus bundle between a system-bus master and the DRAM bridge slave.
// Handshake: a transfer is requested while cyc_i & stb_i are high and completes on the
// single cycle ack_o is high; data_o is valid only in that cycle.
interface dram_wb_bridge_if #(
   parameter int unsigned WORD_SIZE = 256
);
   logic                 cyc_i;
   logic                 stb_i;
   logic                 we_i;
   logic [31:0]          addr_i;
   logic [WORD_SIZE-1:0] data_i;
   logic [WORD_SIZE-1:0] data_o;
   logic                 ack_o;

   modport slave (
      input  cyc_i, stb_i, we_i, addr_i, data_i,
      output data_o, ack_o
   );

   modport master (
      output cyc_i, stb_i, we_i, addr_i, data_i,
      input  data_o, ack_o
   );
endinterface

// File: rtl/dram_wb_cmd_fifo.sv
// Synchronous command FIFO; the head entry is presented combinationally on dout.
// Pushes while full and pops while empty are ignored.
module dram_wb_cmd_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/dram_wb_bridge.sv
// Wishbone classic slave that posts writes into a command FIFO for a DRAM controller and
// acks reads on data return. Define WB_ERR_EN to add err_o for requests made before init.
module dram_wb_bridge
   import dram_wb_pkg::*;
#(
   parameter int unsigned SYS_CLK_FREQ = 100_000_000,
   parameter int unsigned WORD_SIZE    = DEF_WORD_SIZE,
   parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   output logic                  initialized,
   dram_wb_bridge_if.slave       wb,
`ifdef WB_ERR_EN
   output logic                  err_o,
`endif
   input  logic                  mem_init_done,
   output logic                  mem_cmd_valid,
   input  logic                  mem_cmd_ready,
   output logic                  mem_cmd_we,
   output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
   output logic [WORD_SIZE-1:0]  mem_wdata,
   input  logic [WORD_SIZE-1:0]  mem_rdata,
   input  logic                  mem_rdata_valid,
   output state_t                dbg_state
);
   localparam int unsigned unused_clk_freq = SYS_CLK_FREQ;
   localparam int unsigned DW = $clog2(FIFO_DEPTH) + 2;

   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [WORD_SIZE-1:0]  data;
   } bus_cmd_t;

   state_t               state_q, state_d;
   logic                 ack_q, ack_d;
   logic [WORD_SIZE-1:0] data_q, data_d;
   logic                 init_q;
   logic                 read_pending_q, read_pending_d;
   logic [DW-1:0]        drop_cnt_q, drop_cnt_d;
   logic                 push, pop, full, empty, abort;
   logic                 req, rd_take, rd_drop;
   bus_cmd_t             cmd_in, head;
   logic [$bits(bus_cmd_t)-1:0] head_bits;
   logic                 unused_addr_bits;
`ifdef WB_ERR_EN
   logic                 err_q, err_d;
   assign err_o = err_q;
`endif

   assign unused_addr_bits = ^wb.addr_i[31-ADDR_WIDTH:0];
   assign req     = wb.cyc_i & wb.stb_i & init_q;
   assign cmd_in  = '{we: wb.we_i, addr: wb.addr_i[31 -: ADDR_WIDTH], data: wb.data_i};
   assign head    = bus_cmd_t'(head_bits);
   // Returns belonging to aborted reads arrive first (in order) and are swallowed.
   assign rd_drop = mem_rdata_valid & (drop_cnt_q != '0);
   assign rd_take = mem_rdata_valid & (drop_cnt_q == '0) & read_pending_q;

   dram_wb_cmd_fifo #(
      .WIDTH ($bits(bus_cmd_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (sys_clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (cmd_in),
      .dout  (head_bits),
      .full  (full),
      .empty (empty)
   );

   assign mem_cmd_valid = ~empty;
   assign pop           = mem_cmd_valid & mem_cmd_ready;
   assign mem_cmd_we    = head.we;
   assign mem_cmd_addr  = head.addr;
   assign mem_wdata     = head.data;
   assign wb.ack_o      = ack_q;
   assign wb.data_o     = data_q;
   assign initialized   = init_q;
   assign dbg_state     = state_q;

   always_comb begin
      state_d        = state_q;
      ack_d          = 1'b0;
      data_d         = data_q;
      read_pending_d = read_pending_q;
      drop_cnt_d     = drop_cnt_q;
      push           = 1'b0;
      abort          = 1'b0;
`ifdef WB_ERR_EN
      err_d          = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (req && !full) begin
               push = 1'b1;
               if (wb.we_i) begin
                  ack_d   = 1'b1;
                  state_d = ACK;
               end else begin
                  read_pending_d = 1'b1;
                  state_d        = WAIT_RD;
               end
            end
`ifdef WB_ERR_EN
            else if (wb.cyc_i && wb.stb_i && !init_q) begin
               err_d   = 1'b1;
               state_d = ACK;
            end
`endif
         end
         WAIT_RD: begin
            if (rd_take) begin
               data_d         = mem_rdata;
               ack_d          = wb.cyc_i;
               read_pending_d = 1'b0;
               state_d        = ACK;
            end else if (!wb.cyc_i) begin
               abort          = 1'b1;
               read_pending_d = 1'b0;
               state_d        = IDLE;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && !rd_drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DW'(1);
      else if (!abort && rd_drop)                   drop_cnt_d = drop_cnt_q - DW'(1);
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q        <= IDLE;
         ack_q          <= 1'b0;
         data_q         <= '0;
         init_q         <= 1'b0;
         read_pending_q <= 1'b0;
         drop_cnt_q     <= '0;
`ifdef WB_ERR_EN
         err_q          <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         ack_q          <= ack_d;
         data_q         <= data_d;
         init_q         <= mem_init_done;
         read_pending_q <= read_pending_d;
         drop_cnt_q     <= drop_cnt_d;
`ifdef WB_ERR_EN
         err_q          <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_dram_wb_bridge.sv
// Bench for dram_wb_bridge: vector table, multi-cycle corner sequences and random traffic
// against a word-level memory reference and a command-order scoreboard.
module tb_dram_wb_bridge;
   import dram_wb_pkg::*;

   localparam int WS = 256;
   localparam int AW = 25;
   localparam int CW = 1 + AW + WS;

   logic          sys_clk = 1'b0;
   logic          rst;
   logic          initialized;
   logic          mem_init_done;
   logic          mem_cmd_valid;
   logic          mem_cmd_ready;
   logic          mem_cmd_we;
   logic [AW-1:0] mem_cmd_addr;
   logic [WS-1:0] mem_wdata;
   logic [WS-1:0] mem_rdata;
   logic          mem_rdata_valid;
   state_t        dbg_state;
`ifdef WB_ERR_EN
   logic          err_o;
`endif

   dram_wb_bridge_if #(.WORD_SIZE(WS)) wb ();

   dram_wb_bridge dut (
      .sys_clk         (sys_clk),
      .rst             (rst),
      .initialized     (initialized),
      .wb              (wb),
`ifdef WB_ERR_EN
      .err_o           (err_o),
`endif
      .mem_init_done   (mem_init_done),
      .mem_cmd_valid   (mem_cmd_valid),
      .mem_cmd_ready   (mem_cmd_ready),
      .mem_cmd_we      (mem_cmd_we),
      .mem_cmd_addr    (mem_cmd_addr),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .mem_rdata_valid (mem_rdata_valid),
      .dbg_state       (dbg_state)
   );

   // clock / reset
   always #5 sys_clk = ~sys_clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference: bus-level memory and expected command stream
   logic [WS-1:0] ref_mem [logic [AW-1:0]];
   logic [CW-1:0] exp_q [$];
   logic [WS-1:0] last_rd = '0;

   function automatic logic [WS-1:0] ref_read(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : '0;
   endfunction

   function automatic logic [WS-1:0] rand_word();
      logic [WS-1:0] w;
      for (int i = 0; i < WS / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   // DRAM controller model
   logic [WS-1:0] dram_arr [logic [AW-1:0]];
   int            ready_mode = 1;
   int            rd_lat     = 10;
   bit            rand_lat   = 1'b0;
   int            now_cyc    = 0;
   int            rd_due_q [$];
   logic [WS-1:0] rd_dat_q [$];

   initial begin
      mem_cmd_ready   = 1'b0;
      mem_rdata_valid = 1'b0;
      mem_rdata       = '0;
      forever begin
         @(negedge sys_clk);
         now_cyc++;
         if (rd_due_q.size() > 0 && rd_due_q[0] <= now_cyc) begin
            void'(rd_due_q.pop_front());
            mem_rdata       = rd_dat_q.pop_front();
            mem_rdata_valid = 1'b1;
         end else begin
            mem_rdata_valid = 1'b0;
         end
         mem_cmd_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
         if (!rst && mem_cmd_valid && mem_cmd_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL cmd_unexpected: got we=%0b addr=%h expected no command", mem_cmd_we, mem_cmd_addr);
            end else begin
               logic [CW-1:0] e;
               e = exp_q.pop_front();
               check("cmd_we", WS'(mem_cmd_we), WS'(e[CW-1]));
               check("cmd_addr", WS'(mem_cmd_addr), WS'(e[WS +: AW]));
               if (e[CW-1]) begin
                  check("cmd_wdata", mem_wdata, e[WS-1:0]);
                  dram_arr[mem_cmd_addr] = mem_wdata;
               end else begin
                  int due;
                  due = now_cyc + (rand_lat ? $urandom_range(1, 6) : rd_lat);
                  if (rd_due_q.size() > 0 && due <= rd_due_q[$]) due = rd_due_q[$] + 1;
                  rd_due_q.push_back(due);
                  rd_dat_q.push_back(dram_arr.exists(mem_cmd_addr) ? dram_arr[mem_cmd_addr] : '0);
               end
            end
         end
      end
   end

   // driver: full bus transfer; called #1 after a rising edge
   task automatic wb_xfer(input bit we, input logic [AW-1:0] word, input logic [WS-1:0] wdata,
                          output logic [WS-1:0] rdata, output int lat);
      bit got;
      exp_q.push_back({we, word, we ? wdata : {WS{1'b0}}});
      wb.cyc_i  = 1'b1;
      wb.stb_i  = 1'b1;
      wb.we_i   = we;
      wb.addr_i = {word, 7'b0};
      wb.data_i = wdata;
      got = 1'b0;
      lat = 0;
      rdata = '0;
      for (int i = 1; i <= 300; i++) begin
         @(posedge sys_clk);
         #1;
         if (wb.ack_o) begin
            got   = 1'b1;
            lat   = i;
            rdata = wb.data_o;
            break;
         end
      end
      wb.cyc_i = 1'b0;
      wb.stb_i = 1'b0;
      wb.we_i  = 1'b0;
      check("ack_seen", WS'(got), WS'(1));
      if (got) begin
         if (we) ref_mem[word] = wdata;
         @(posedge sys_clk);
         #1;
         check("ack_one_cycle", WS'(wb.ack_o), WS'(0));
      end
   endtask

   typedef struct {
      bit            we;
      logic [AW-1:0] word;
      logic [WS-1:0] wdata;
      logic [WS-1:0] exp_rdata;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [WS-1:0] rd, xdat;
      int            lat, bad;

      vecs[0] = '{1'b1, 25'h0,       {32{8'hA5}},   '0};
      vecs[1] = '{1'b0, 25'h0,       '0,            {32{8'hA5}}};
      vecs[2] = '{1'b1, 25'h1FFFFFF, {32{8'h3C}},   '0};
      vecs[3] = '{1'b0, 25'h1FFFFFF, '0,            {32{8'h3C}}};
      vecs[4] = '{1'b1, 25'h5,       {8{32'hDEADBEEF}}, '0};
      vecs[5] = '{1'b1, 25'h5,       {8{32'h12345678}}, '0};
      vecs[6] = '{1'b0, 25'h5,       '0,            {8{32'h12345678}}};
      vecs[7] = '{1'b0, 25'h9,       '0,            '0};
      vecs[8] = '{1'b1, 25'h0,       {WS{1'b1}},    '0};
      vecs[9] = '{1'b0, 25'h0,       '0,            {WS{1'b1}}};

      rst           = 1'b1;
      mem_init_done = 1'b0;
      wb.cyc_i      = 1'b0;
      wb.stb_i      = 1'b0;
      wb.we_i       = 1'b0;
      wb.addr_i     = '0;
      wb.data_i     = '0;
      repeat (3) @(posedge sys_clk);
      #1;
      rst = 1'b0;

      check("rst_ack", WS'(wb.ack_o), WS'(0));
      check("rst_data", wb.data_o, '0);
      check("rst_init", WS'(initialized), WS'(0));
      check("rst_valid", WS'(mem_cmd_valid), WS'(0));
      check("rst_state", WS'(dbg_state), WS'(IDLE));

      // request before calibration completes
      wb.cyc_i  = 1'b1;
      wb.stb_i  = 1'b1;
      wb.we_i   = 1'b1;
      wb.addr_i = '0;
      wb.data_i = {32{8'h77}};
`ifdef WB_ERR_EN
      @(posedge sys_clk);
      #1;
      check("err_pulse", WS'(err_o), WS'(1));
      check("err_no_ack", WS'(wb.ack_o), WS'(0));
      wb.cyc_i = 1'b0;
      wb.stb_i = 1'b0;
      @(posedge sys_clk);
      #1;
      check("err_one_cycle", WS'(err_o), WS'(0));
      check("err_no_push", WS'(mem_cmd_valid), WS'(0));
      repeat (4) @(posedge sys_clk);
      #1;
`else
      bad = 0;
      repeat (6) begin
         @(posedge sys_clk);
         #1;
         if (wb.ack_o || mem_cmd_valid) bad++;
      end
      check("uninit_stall", WS'(bad), WS'(0));
      wb.cyc_i = 1'b0;
      wb.stb_i = 1'b0;
`endif
      check("init_low", WS'(initialized), WS'(0));
      mem_init_done = 1'b1;
      check("init_not_yet", WS'(initialized), WS'(0));
      @(posedge sys_clk);
      #1;
      check("init_high", WS'(initialized), WS'(1));
      mem_init_done = 1'b0;
      @(posedge sys_clk);
      #1;
      check("init_drop", WS'(initialized), WS'(0));
      mem_init_done = 1'b1;
      @(posedge sys_clk);
      #1;

      // table vectors
      ready_mode = 1;
      rd_lat     = 10;
      for (int i = 0; i < 10; i++) begin
         wb_xfer(vecs[i].we, vecs[i].word, vecs[i].wdata, rd, lat);
         if (vecs[i].we) begin
            check($sformatf("vec%0d_wr_lat", i), WS'(lat), WS'(1));
         end else begin
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_rd_lat", i), WS'(lat > 10), WS'(1));
            last_rd = vecs[i].exp_rdata;
         end
      end

      // FIFO full: 8 posted writes, the ninth stalls until the controller accepts
      repeat (5) @(posedge sys_clk);
      #1;
      ready_mode = 0;
      for (int i = 0; i < 8; i++) begin
         wb_xfer(1'b1, AW'(40 + i), {8{32'h4000_0000 + i}}, rd, lat);
         check("full_wr_lat", WS'(lat), WS'(1));
      end
      exp_q.push_back({1'b1, AW'(48), {8{32'h4000_0008}}});
      wb.cyc_i  = 1'b1;
      wb.stb_i  = 1'b1;
      wb.we_i   = 1'b1;
      wb.addr_i = {AW'(48), 7'b0};
      wb.data_i = {8{32'h4000_0008}};
      bad = 0;
      repeat (6) begin
         @(posedge sys_clk);
         #1;
         if (wb.ack_o) bad++;
      end
      check("full_stall", WS'(bad), WS'(0));
      ready_mode = 1;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge sys_clk);
         #1;
         if (wb.ack_o) begin
            lat = i;
            break;
         end
      end
      wb.cyc_i = 1'b0;
      wb.stb_i = 1'b0;
      wb.we_i  = 1'b0;
      check("full_release_ack", WS'(lat != 0), WS'(1));
      if (lat != 0) ref_mem[AW'(48)] = {8{32'h4000_0008}};
      repeat (12) @(posedge sys_clk);
      #1;

      // abort a read: its return is discarded, no ack, FSM idle
      rd_lat = 10;
      exp_q.push_back({1'b0, AW'(40), {WS{1'b0}}});
      wb.cyc_i  = 1'b1;
      wb.stb_i  = 1'b1;
      wb.we_i   = 1'b0;
      wb.addr_i = {AW'(40), 7'b0};
      bad = 0;
      repeat (3) begin
         @(posedge sys_clk);
         #1;
         if (wb.ack_o) bad++;
      end
      wb.cyc_i = 1'b0;
      wb.stb_i = 1'b0;
      repeat (20) begin
         @(posedge sys_clk);
         #1;
         if (wb.ack_o) bad++;
      end
      check("abort_no_ack", WS'(bad), WS'(0));
      check("abort_data_hold", wb.data_o, last_rd);
      check("abort_idle", WS'(dbg_state), WS'(IDLE));
      xdat = {8{32'hCAFE_0001}};
      wb_xfer(1'b1, AW'(1), xdat, rd, lat);
      check("post_abort_wr_lat", WS'(lat), WS'(1));
      wb_xfer(1'b0, AW'(1), '0, rd, lat);
      check("post_abort_rdata", rd, xdat);
      last_rd = xdat;

      // abort with the stale return still in flight when the next read is issued
      rd_lat = 15;
      exp_q.push_back({1'b0, AW'(40), {WS{1'b0}}});
      wb.cyc_i  = 1'b1;
      wb.stb_i  = 1'b1;
      wb.we_i   = 1'b0;
      wb.addr_i = {AW'(40), 7'b0};
      repeat (2) @(posedge sys_clk);
      #1;
      wb.cyc_i = 1'b0;
      wb.stb_i = 1'b0;
      @(posedge sys_clk);
      #1;
      rd_lat = 3;
      wb_xfer(1'b0, AW'(1), '0, rd, lat);
      check("stale_return_dropped", rd, ref_read(AW'(1)));
      last_rd = ref_read(AW'(1));

      // random traffic against the reference
      ready_mode = 2;
      rand_lat   = 1'b1;
      for (int n = 0; n < 120; n++) begin
         bit            we;
         logic [AW-1:0] w;
         logic [WS-1:0] d;
         we = 1'($urandom_range(0, 1));
         w  = AW'($urandom_range(0, 7));
         d  = rand_word();
         if (we) begin
            wb_xfer(1'b1, w, d, rd, lat);
         end else begin
            logic [WS-1:0] exp_d;
            exp_d = ref_read(w);
            wb_xfer(1'b0, w, '0, rd, lat);
            check($sformatf("rand%0d_rdata", n), rd, exp_d);
         end
         repeat ($urandom_range(0, 2)) @(posedge sys_clk);
         #1;
      end

      ready_mode = 1;
      for (int i = 0; i < 200 && (exp_q.size() != 0 || rd_due_q.size() != 0); i++) begin
         @(posedge sys_clk);
         #1;
      end
      check("cmd_drain", WS'(exp_q.size()), WS'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
